// File: rtl/arb_pkg.sv
// arb_pkg -- shared definitions for the priority scan arbiter.
//   arb_state_t : FSM state encoding (IDLE / SCAN / GRANT)
//   N_REQ       : number of requesters (4)
//   PRIO_W      : priority field width per requester (2)
//   TIMEOUT_CYC : default grant watchdog limit in cycles (15)
package arb_pkg;

    localparam int N_REQ       = 4;
    localparam int PRIO_W      = 2;
    localparam int TIMEOUT_CYC = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/prio_gt_cmp.sv
// prio_gt_cmp -- unsigned "strictly greater than" comparator for 2-bit
// priorities. Purely combinational.
//   a   : in  [1:0]  candidate priority
//   b   : in  [1:0]  current best priority
//   res : out        1 when a > b
module prio_gt_cmp (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       res
);

    assign res = (a > b);

endmodule

// File: rtl/prio_scan_arbiter.sv
// prio_scan_arbiter -- sequential priority arbiter. A nonzero request
// vector seen in IDLE is snapshotted (with priorities), then SCAN visits
// one candidate per cycle in round-robin order starting at rr_ptr and
// keeps the highest priority seen (ties keep the earliest candidate).
// GRANT drives the winner until its live request drops.
//
// Optional feature: define ARB_WATCHDOG_EN to force a grant release after
// TIMEOUT_CYC cycles of continuous grant, flagged by a one-cycle timeout.
//
// Ports:
//   clk        : in   clock, rising edge
//   rst        : in   synchronous active-high reset
//   req        : in   [N_REQ-1:0] request levels
//   prio       : in   [N_REQ*PRIO_W-1:0] priorities, requester i at [2i+1:2i]
//   gnt        : out  [N_REQ-1:0] one-hot grant or zero
//   gnt_idx    : out  [1:0] binary index of the granted requester
//   gnt_valid  : out  high exactly when gnt is nonzero
//   busy       : out  high in SCAN and GRANT
//   timeout    : out  one-cycle pulse on a watchdog release (0 without it)
//   dbg_state  : out  [1:0] current FSM state (arb_pkg::arb_state_t)
//   dbg_rr_ptr : out  [1:0] round-robin start pointer
//
// Handshake: req is a level; a requester keeps req high while it wants the
// resource and the grant is held until that level drops (or the watchdog
// fires). gnt is registered: it rises N_REQ+1 cycles after the sampling
// edge and falls on the edge after req[best] is seen low.
module prio_scan_arbiter #(
    parameter int N_REQ       = arb_pkg::N_REQ,
    parameter int PRIO_W      = arb_pkg::PRIO_W,
    parameter int TIMEOUT_CYC = arb_pkg::TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PRIO_W-1:0]   prio,
    output logic [N_REQ-1:0]          gnt,
    output logic [1:0]                gnt_idx,
    output logic                      gnt_valid,
    output logic                      busy,
    output logic                      timeout,
    output logic [1:0]                dbg_state,
    output logic [1:0]                dbg_rr_ptr
);

    import arb_pkg::*;

    arb_state_t                state_q, state_d;
    logic [1:0]                k_q, k_d;
    logic [1:0]                rr_q, rr_d;
    logic [1:0]                best_q, best_d;
    logic                      best_vld_q, best_vld_d;
    logic [N_REQ-1:0]          req_snap_q, req_snap_d;
    logic [N_REQ*PRIO_W-1:0]   prio_snap_q, prio_snap_d;
    // gnt_on separates the first GRANT cycle (result settling) from the
    // cycles in which the grant is actually driven.
    logic                      gnt_on_q, gnt_on_d;

    logic [1:0]        cand;
    logic [PRIO_W-1:0] cand_prio;
    logic [PRIO_W-1:0] best_prio;
    logic              cand_gt;
    logic              wd_expired;

    assign cand      = rr_q + k_q;   // 2-bit add wraps mod 4
    assign cand_prio = prio_snap_q[{cand, 1'b0} +: PRIO_W];
    assign best_prio = prio_snap_q[{best_q, 1'b0} +: PRIO_W];

    prio_gt_cmp u_cmp (
        .a   (cand_prio),
        .b   (best_prio),
        .res (cand_gt)
    );

`ifdef ARB_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // wd_q counts completed grant cycles; at WD_LAST the coming edge ends
    // the TIMEOUT_CYC-th cycle of grant.
    assign wd_expired = gnt_on_q && (wd_q == WD_LAST) && req[best_q];

    always_comb begin
        wd_d      = '0;
        timeout_d = 1'b0;
        if (state_q == GRANT && gnt_on_q && req[best_q]) begin
            if (wd_expired) begin
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rr_d        = rr_q;
        best_d      = best_q;
        best_vld_d  = best_vld_q;
        req_snap_d  = req_snap_q;
        prio_snap_d = prio_snap_q;
        gnt_on_d    = gnt_on_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    req_snap_d  = req;
                    prio_snap_d = prio;
                    k_d         = 2'd0;
                    best_vld_d  = 1'b0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (req_snap_q[cand] && (!best_vld_q || cand_gt)) begin
                    best_d     = cand;
                    best_vld_d = 1'b1;
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'(N_REQ - 1)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!gnt_on_q) begin
                    gnt_on_d = 1'b1;
                end else if (!req[best_q] || wd_expired) begin
                    gnt_on_d   = 1'b0;
                    best_vld_d = 1'b0;
                    k_d        = 2'd0;
                    rr_d       = best_q + 2'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_on_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            rr_q        <= 2'd0;
            best_q      <= 2'd0;
            best_vld_q  <= 1'b0;
            req_snap_q  <= '0;
            prio_snap_q <= '0;
            gnt_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rr_q        <= rr_d;
            best_q      <= best_d;
            best_vld_q  <= best_vld_d;
            req_snap_q  <= req_snap_d;
            prio_snap_q <= prio_snap_d;
            gnt_on_q    <= gnt_on_d;
        end
    end

    assign gnt        = gnt_on_q ? (N_REQ'(1) << best_q) : '0;
    assign gnt_idx    = gnt_on_q ? best_q : 2'd0;
    assign gnt_valid  = gnt_on_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_q;

endmodule

// File: tb/tb_prio_scan_arbiter.sv
// tb_prio_scan_arbiter -- self-checking bench for prio_scan_arbiter.
// Vector table of single transactions, hand-written corner sequences,
// then randomized transactions checked against a max-then-rotation model.
module tb_prio_scan_arbiter;

  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] prio;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;
  logic       timeout;
  logic [1:0] dbg_state;
  logic [1:0] dbg_rr_ptr;

  int total = 0;
  int bad   = 0;
  int model_rr = 0;

  prio_scan_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .prio       (prio),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .busy       (busy),
    .timeout    (timeout),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'd0;
    prio = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    model_rr = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: highest priority among set requests, ties broken by the
  // first such requester in the rotation that starts at rr.
  function automatic int model_winner(input logic [3:0] r, input logic [7:0] p, input int rr);
    int maxp = -1;
    for (int i = 0; i < 4; i++) begin
      int pi = int'((p >> (2 * i)) & 8'h3);
      if (r[i] && pi > maxp) maxp = pi;
    end
    for (int k = 0; k < 4; k++) begin
      int c = (rr + k) % 4;
      if (r[c] && int'((p >> (2 * c)) & 8'h3) == maxp) return c;
    end
    return -1;
  endfunction

  // driver: one full transaction from IDLE; checks latency, grant, release
  task automatic run_txn(input logic [3:0] r, input logic [7:0] p, input int hold,
                         input int exp_idx, input bit garbage);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << exp_idx;
    req  = r;
    prio = p;
    tick();                               // sampling edge t
    check("busy_after_sample", busy, 1);
    for (int i = 0; i < 3; i++) begin     // edges t+1..t+3
      if (garbage) begin
        req  = 4'($urandom);
        prio = 8'($urandom);
      end
      tick();
    end
    req = r;
    tick();                               // edge t+4
    check("gnt_not_early", gnt, 0);
    tick();                               // edge t+5
    check("gnt", gnt, exp_gnt);
    check("gnt_idx", gnt_idx, exp_idx);
    check("gnt_valid", gnt_valid, 1);
    for (int j = 1; j < hold; j++) begin
      tick();
      check("gnt_hold", gnt, exp_gnt);
    end
    req = 4'd0;
    tick();
    check("gnt_release", gnt, 0);
    check("valid_release", gnt_valid, 0);
    check("rr_after", dbg_rr_ptr, (exp_idx + 1) % 4);
    model_rr = (exp_idx + 1) % 4;
  endtask

  typedef struct {
    logic [3:0] r;
    logic [7:0] p;
    int         hold;
    int         exp_idx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    int guard;
    bit to_early;
    bit any_gnt;

    // table filled in order; rr starts at 0 and follows each winner
    vecs[0] = '{4'b0010, 8'h04, 1, 1};  // single requester, rr -> 2
    vecs[1] = '{4'b1111, 8'h72, 2, 2};  // prio 3:1 2:3 1:0 0:2, rr -> 3
    vecs[2] = '{4'b0101, 8'h55, 3, 0};  // tie, rr=3 -> 0 first, rr -> 1
    vecs[3] = '{4'b1001, 8'hFF, 1, 3};  // tie, rr=1 -> 3 first, rr -> 0
    vecs[4] = '{4'b1000, 8'h00, 2, 3};  // lone prio-0 requester, rr -> 0
    vecs[5] = '{4'b0110, 8'h3C, 1, 1};  // tie 1/2 from rr=0, rr -> 2
    vecs[6] = '{4'b1011, 8'h88, 2, 3};  // tie 1/3 from rr=2, rr -> 0
    vecs[7] = '{4'b0011, 8'h07, 1, 0};  // prio 0:3 beats 1:1, rr -> 1

    // reset state, checked while rst is still asserted
    rst  = 1'b1;
    req  = 4'b1111;
    prio = 8'hFF;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_gnt_idx", gnt_idx, 0);
    check("rst_gnt_valid", gnt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rr", dbg_rr_ptr, 0);
    check("rst_state", dbg_state, 32'(IDLE));
    do_reset();

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].r, vecs[v].p, vecs[v].hold, vecs[v].exp_idx, 1'b0);
    end

    // snapshot/drop: winner drops in SCAN, another raises -> one-cycle grant
    req  = 4'b0001;
    prio = 8'h00;
    tick();
    req = 4'b1000;
    repeat (3) tick();
    tick();
    check("drop_not_early", gnt, 0);
    tick();
    check("drop_gnt", gnt, 4'b0001);
    tick();
    check("drop_one_cycle", gnt, 0);
    check("drop_rr", dbg_rr_ptr, 1);
    tick();                               // IDLE samples req=1000
    repeat (4) tick();
    tick();
    check("drop_next_gnt", gnt, 4'b1000);
    check("drop_next_idx", gnt_idx, 3);
    req = 4'd0;
    tick();
    check("drop_next_release", gnt, 0);
    check("drop_next_rr", dbg_rr_ptr, 0);

    // reset mid-SCAN with rr nonzero
    run_txn(4'b0010, 8'h00, 1, 1, 1'b0);
    req  = 4'b1111;
    prio = 8'hAA;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("scan_rst_gnt", gnt, 0);
    check("scan_rst_valid", gnt_valid, 0);
    check("scan_rst_busy", busy, 0);
    check("scan_rst_rr", dbg_rr_ptr, 0);
    rst = 1'b0;
    req = 4'd0;
    any_gnt = 1'b0;
    repeat (8) begin
      tick();
      if (gnt != 0) any_gnt = 1'b1;
    end
    check("scan_rst_no_grant", any_gnt, 0);

    // reset mid-GRANT drops gnt at that edge
    req = 4'b0100;
    tick();
    repeat (5) tick();
    check("grant_rst_pre", gnt, 4'b0100);
    rst = 1'b1;
    tick();
    check("grant_rst_gnt", gnt, 0);
    check("grant_rst_busy", busy, 0);
    do_reset();

    // tie rotation from reset
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 8'hAA, 2, i % 4, 1'b0);
    end

    // watchdog
    do_reset();
    req  = 4'b0001;
    prio = 8'h00;
    tick();
    repeat (5) tick();
    check("wd_gnt_on", gnt, 4'b0001);
    cnt = 0;
    guard = 0;
    to_early = 1'b0;
    while (gnt != 0 && guard < 40) begin
      cnt++;
      if (timeout) to_early = 1'b1;
      tick();
      guard++;
    end
    check("wd_no_early_timeout", to_early, 0);
`ifdef ARB_WATCHDOG_EN
    check("wd_gnt_cycles", cnt, 15);
    check("wd_timeout_pulse", timeout, 1);
    check("wd_gnt_low", gnt, 0);
    check("wd_rr", dbg_rr_ptr, 1);
    req = 4'd0;
    tick();
    check("wd_timeout_one_cycle", timeout, 0);
`else
    check("wd_gnt_held", cnt, 40);
    check("wd_timeout_zero", timeout, 0);
    req = 4'd0;
    tick();
    check("wd_release", gnt, 0);
    check("wd_rr", dbg_rr_ptr, 1);
`endif

    // randomized transactions against the reference model
    do_reset();
    for (int t = 0; t < 30; t++) begin
      logic [3:0] r;
      logic [7:0] p;
      r = 4'($urandom_range(1, 15));
      p = 8'($urandom);
      run_txn(r, p, $urandom_range(1, 4), model_winner(r, p, model_rr), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
